dataslot_cmd_scheduler: RTL
===========================

Name: dataslot_cmd_scheduler

Overview:
- Shares the single target-dataslot command channel of core_bridge_cmd between NUM_REQ on-core requesters, for example high-score save/load and NVRAM flush.
- Round-robin arbitrates among pending requests and latches the winner's parameters.
- Drives the read/write strobe handshake through ack and done, then returns a per-requester completion pulse with error and timeout status.
- Sits in clk_74a domain between jailbreak_core sub-blocks and core_bridge_cmd target ports.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
TIMEOUT_CYCLES, 32'd74_250_000, cycles allowed in WAIT_ACK or WAIT_DONE before abort (1 s at 74.25 MHz)
IDX_W, $clog2(NUM_REQ) min 1, internal grant index width

Ports:
clk_74a  in  1  core bridge clock; all logic synchronous to it
reset  in  1  asynchronous, active-high
req_valid  in  NUM_REQ  request pending, held until req_ready
req_write  in  NUM_REQ  1=dataslot write, 0=dataslot read
req_id  in  NUM_REQ*16  dataslot id per requester
req_slotoffset  in  NUM_REQ*32  byte offset in slot
req_bridgeaddr  in  NUM_REQ*32  bridge address of data
req_length  in  NUM_REQ*32  byte length
req_ready  out  NUM_REQ  one-cycle accept pulse, onehot
rsp_done  out  NUM_REQ  one-cycle completion pulse, onehot, to the granted requester
rsp_err  out  3  err of last completion, valid with rsp_done
rsp_timeout  out  1  last completion aborted by timeout, valid with rsp_done
busy  out  1  state != IDLE
target_dataslot_read  out  1  read strobe to core_bridge_cmd
target_dataslot_write  out  1  write strobe
target_dataslot_id  out  16  latched id
target_dataslot_slotoffset  out  32  latched offset
target_dataslot_bridgeaddr  out  32  latched address
target_dataslot_length  out  32  latched length
target_dataslot_ack  in  1  command accepted, high until completion
target_dataslot_done  in  1  command finished
target_dataslot_err  in  3  error code, sampled with done

Behaviour:
- Reset state:
  - All outputs 0; rr_ptr=0; state IDLE; timeout counter 0.
  - Reset asserted mid-operation drops strobes immediately; no rsp_done is issued for the aborted request.
- IDLE:
  - If any req_valid is set, grant the first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Pulse req_ready[g] for 1 cycle.
  - Latch g, req_write[g] and the four fields into target_dataslot_*.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Go to ISSUE.
  - With no request pending, stay in IDLE.
- ISSUE (1 cycle):
  - Assert target_dataslot_read or _write per the latched write bit. Only one strobe is ever high.
  - Clear the timeout counter. Go to WAIT_ACK.
- WAIT_ACK:
  - Hold the strobe high.
  - On ack=1: drop the strobe the next cycle, clear the counter, go to WAIT_DONE.
  - If ack and done are both seen in the same cycle, go straight to COMPLETE with err captured.
- WAIT_DONE:
  - Strobe low. On done=1: capture err, go to COMPLETE.
- Timeout:
  - Counter increments each cycle in WAIT_ACK and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES-1, drop the strobe, set timeout flag, set err=3'b111, go to COMPLETE.
- COMPLETE (1 cycle):
  - Pulse rsp_done[g].
  - Drive rsp_err and rsp_timeout; both hold their value until the next COMPLETE.
  - Go to RELEASE.
- RELEASE:
  - Wait until ack=0 and done=0, so the next strobe is a clean rising edge, then go to IDLE.
  - After a timeout, ignore the inputs and return to IDLE immediately.
- Latency and stability:
  - Latched target_dataslot_* fields are stable from ISSUE through RELEASE.
  - Request fields may change after req_ready.
  - Min req_valid-to-strobe latency: 2 cycles (IDLE, then ISSUE).
  - Min back-to-back command spacing: 5 cycles.
- Requester rules:
  - A requester must not re-raise req_valid before its rsp_done; RTL does not check this.
  - A requester dropping req_valid before grant is legal, and that request is skipped.

Test Plan:
1. Single read, req0 id=16'h0004, len=32'h100, ack at +3, done at +10, err=0:
   - read strobe high exactly from ISSUE until the cycle after ack; write stays 0.
   - rsp_done=2'b01, rsp_err=0, rsp_timeout=0.
2. Both requesters valid at once after reset:
   - req_ready order 01, then 10.
   - After re-requesting both, grants alternate 01, 10 (round-robin fairness).
3. Write with done err=3'b010:
   - target_dataslot_write asserted and read never asserted.
   - rsp_done pulse carries rsp_err=3'b010.
4. Ack never arrives, TIMEOUT_CYCLES=16:
   - strobe drops after 16 cycles in WAIT_ACK.
   - rsp_timeout=1, rsp_err=3'b111, busy=0 one cycle later.
5. Reset pulsed in WAIT_DONE:
   - strobes and busy go 0 asynchronously; no rsp_done.
   - Next request is granted from rr_ptr=0.
6. Ack and done held high for 4 cycles after done:
   - FSM stays in RELEASE, with no new strobe, until both are low, even with req1 pending.

Source files
------------

// File: rtl/dataslot_cmd_scheduler_if.sv
// Target-dataslot command channel between the scheduler and core_bridge_cmd.
interface dataslot_cmd_scheduler_if;
    logic        target_dataslot_read;
    logic        target_dataslot_write;
    logic [15:0] target_dataslot_id;
    logic [31:0] target_dataslot_slotoffset;
    logic [31:0] target_dataslot_bridgeaddr;
    logic [31:0] target_dataslot_length;
    logic        target_dataslot_ack;
    logic        target_dataslot_done;
    logic [2:0]  target_dataslot_err;

    modport master (
        output target_dataslot_read,
        output target_dataslot_write,
        output target_dataslot_id,
        output target_dataslot_slotoffset,
        output target_dataslot_bridgeaddr,
        output target_dataslot_length,
        input  target_dataslot_ack,
        input  target_dataslot_done,
        input  target_dataslot_err
    );

    modport slave (
        input  target_dataslot_read,
        input  target_dataslot_write,
        input  target_dataslot_id,
        input  target_dataslot_slotoffset,
        input  target_dataslot_bridgeaddr,
        input  target_dataslot_length,
        output target_dataslot_ack,
        output target_dataslot_done,
        output target_dataslot_err
    );
endinterface

// File: rtl/dataslot_cmd_scheduler.sv
// Round-robin sharing of the core_bridge_cmd target-dataslot channel
// between NUM_REQ on-core requesters, with ack/done handshake and timeout.
module dataslot_cmd_scheduler #(
    parameter int unsigned NUM_REQ        = 2,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd74_250_000,
    parameter int unsigned IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk_74a,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ*16-1:0]   req_id,
    input  logic [NUM_REQ*32-1:0]   req_slotoffset,
    input  logic [NUM_REQ*32-1:0]   req_bridgeaddr,
    input  logic [NUM_REQ*32-1:0]   req_length,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_done,
    output logic [2:0]              rsp_err,
    output logic                    rsp_timeout,
    output logic                    busy,
    dataslot_cmd_scheduler_if.master tgt
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_COMPLETE, S_RELEASE
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic             write_q, write_d;
    logic [15:0]      id_q, id_d;
    logic [31:0]      off_q, off_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      len_q, len_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [2:0]       err_q, err_d;
    logic             tmo_q, tmo_d;

    logic             found;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] nxt_rr;
    logic             sel_write;
    logic [15:0]      sel_id;
    logic [31:0]      sel_off;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_len;
    logic             grant;
    logic             tmo_hit;
    logic             fin_ok;
    logic             fin_tmo;
    logic             to_wd;
    logic             ack;
    logic             done;

    assign ack     = tgt.target_dataslot_ack;
    assign done    = tgt.target_dataslot_done;
    assign tmo_hit = (cnt_q == TIMEOUT_CYCLES - 32'd1);
    assign grant   = (state_q == S_IDLE) && found;

    // first valid requester scanning upward from rr_q, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(rr_q) + 32'(i)) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        nxt_rr = IDX_W'((32'(pick) + 32'd1) % NUM_REQ);
    end

    always_comb begin
        sel_write = 1'b0;
        sel_id    = '0;
        sel_off   = '0;
        sel_addr  = '0;
        sel_len   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                sel_write = req_write[i];
                sel_id    = req_id[i*16 +: 16];
                sel_off   = req_slotoffset[i*32 +: 32];
                sel_addr  = req_bridgeaddr[i*32 +: 32];
                sel_len   = req_length[i*32 +: 32];
            end
        end
    end

    // ack+done together skips WAIT_DONE; a real response beats a timeout
    always_comb begin
        fin_ok  = 1'b0;
        fin_tmo = 1'b0;
        to_wd   = 1'b0;
        unique case (state_q)
            S_WAIT_ACK: begin
                fin_ok  = ack && done;
                to_wd   = ack && !done;
                fin_tmo = !ack && tmo_hit;
            end
            S_WAIT_DONE: begin
                fin_ok  = done;
                fin_tmo = !done && tmo_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (found) state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (fin_ok || fin_tmo) state_d = S_COMPLETE;
                else if (to_wd)        state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: if (fin_ok || fin_tmo) state_d = S_COMPLETE;
            S_COMPLETE:  state_d = S_RELEASE;
            S_RELEASE:   if (tmo_q || (!ack && !done)) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_done  = '0;
        tgt.target_dataslot_read  = 1'b0;
        tgt.target_dataslot_write = 1'b0;
        unique case (state_q)
            S_IDLE: if (found) req_ready[pick] = 1'b1;
            S_ISSUE, S_WAIT_ACK: begin
                tgt.target_dataslot_read  = !write_q;
                tgt.target_dataslot_write = write_q;
            end
            S_COMPLETE: rsp_done[gnt_q] = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        write_d = write_q;
        id_d    = id_q;
        off_d   = off_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        if (grant) begin
            gnt_d   = pick;
            rr_d    = nxt_rr;
            write_d = sel_write;
            id_d    = sel_id;
            off_d   = sel_off;
            addr_d  = sel_addr;
            len_d   = sel_len;
        end
        if (state_q == S_ISSUE || to_wd) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT_ACK || state_q == S_WAIT_DONE) begin
            cnt_d = cnt_q + 32'd1;
        end
        if (fin_ok) begin
            err_d = tgt.target_dataslot_err;
            tmo_d = 1'b0;
        end else if (fin_tmo) begin
            err_d = 3'b111;
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            rr_q    <= '0;
            gnt_q   <= '0;
            write_q <= 1'b0;
            id_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            write_q <= write_d;
            id_q    <= id_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign rsp_err                        = err_q;
    assign rsp_timeout                    = tmo_q;
    assign busy                           = (state_q != S_IDLE);
    assign tgt.target_dataslot_id         = id_q;
    assign tgt.target_dataslot_slotoffset = off_q;
    assign tgt.target_dataslot_bridgeaddr = addr_q;
    assign tgt.target_dataslot_length     = len_q;
endmodule
